// File: rtl/mempool_group_link_pkg.sv
// Shared constants and TCDM payload types for the inter-group link.
package mempool_group_link_pkg;

    localparam int unsigned NumTilesPerGroup   = 4;
    localparam int unsigned LinkMaxOutstanding = 4;
    localparam int unsigned AddrW              = 16;
    localparam int unsigned DataW              = 32;
    localparam int unsigned BeW                = DataW / 8;
    localparam int unsigned MetaW              = 8;

    typedef struct packed {
        logic [AddrW-1:0] tgt_addr;
        logic             wen;
        logic [DataW-1:0] wdata;
        logic [BeW-1:0]   be;
        logic [MetaW-1:0] meta_id;
    } tcdm_slave_req_t;

    typedef struct packed {
        logic [DataW-1:0] rdata;
        logic [MetaW-1:0] meta_id;
    } tcdm_master_resp_t;

    // Pointer width for a FIFO of the given depth, never zero.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/mempool_group_link_lane.sv
// One link lane: registered request FIFO, response FIFO sized to the
// outstanding bound, outstanding counter and spurious-response detect.
module mempool_group_link_lane
    import mempool_group_link_pkg::*;
#(
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned MaxOutstanding = LinkMaxOutstanding
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tcdm_slave_req_t   slv_req_i,
    input  logic              slv_req_valid_i,
    output logic              slv_req_ready_o,
    output tcdm_master_resp_t slv_resp_o,
    output logic              slv_resp_valid_o,
    input  logic              slv_resp_ready_i,
    output tcdm_slave_req_t   mst_req_o,
    output logic              mst_req_valid_o,
    input  logic              mst_req_ready_i,
    input  tcdm_master_resp_t mst_resp_i,
    input  logic              mst_resp_valid_i,
    output logic              mst_resp_ready_o,
    output logic              idle_c_o,
    output logic              spur_c_o
);

    localparam int unsigned ReqPtrW = ptr_w(ReqDepth);
    localparam int unsigned ReqCntW = $clog2(ReqDepth + 1);
    localparam int unsigned RspPtrW = ptr_w(MaxOutstanding);
    localparam int unsigned RspCntW = $clog2(MaxOutstanding + 1);

    tcdm_slave_req_t   r_req_mem [ReqDepth];
    logic [ReqPtrW-1:0] r_req_wptr, r_req_rptr;
    logic [ReqCntW-1:0] r_req_cnt;
    tcdm_master_resp_t r_rsp_mem [MaxOutstanding];
    logic [RspPtrW-1:0] r_rsp_wptr, r_rsp_rptr;
    logic [RspCntW-1:0] r_rsp_cnt;
    logic [RspCntW-1:0] r_out_cnt;

    logic w_req_push, w_req_pop, w_rsp_push, w_rsp_pop, w_spur;

    // Handshakes; ready depends on registered state only.
    assign slv_req_ready_o  = (r_req_cnt != ReqCntW'(ReqDepth)) &&
                              (r_out_cnt < RspCntW'(MaxOutstanding));
    assign mst_resp_ready_o = (r_rsp_cnt != RspCntW'(MaxOutstanding));
    assign mst_req_valid_o  = (r_req_cnt != '0);
    assign slv_resp_valid_o = (r_rsp_cnt != '0);
    assign mst_req_o        = r_req_mem[r_req_rptr];
    assign slv_resp_o       = r_rsp_mem[r_rsp_rptr];

    assign w_req_push = slv_req_valid_i && slv_req_ready_o;
    assign w_req_pop  = mst_req_valid_o && mst_req_ready_i;
    assign w_spur     = mst_resp_valid_i && mst_resp_ready_o && (r_out_cnt == '0);
    assign w_rsp_push = mst_resp_valid_i && mst_resp_ready_o && !w_spur;
    assign w_rsp_pop  = slv_resp_valid_o && slv_resp_ready_i;

    assign spur_c_o = w_spur;
    assign idle_c_o = (r_out_cnt == '0) && (r_req_cnt == '0) && (r_rsp_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (w_req_push) r_req_mem[r_req_wptr] <= slv_req_i;
        if (w_rsp_push) r_rsp_mem[r_rsp_wptr] <= mst_resp_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req_wptr <= '0;
            r_req_rptr <= '0;
            r_req_cnt  <= '0;
            r_rsp_wptr <= '0;
            r_rsp_rptr <= '0;
            r_rsp_cnt  <= '0;
            r_out_cnt  <= '0;
        end else begin
            if (w_req_push)
                r_req_wptr <= (r_req_wptr == ReqPtrW'(ReqDepth - 1)) ? '0 : r_req_wptr + 1'b1;
            if (w_req_pop)
                r_req_rptr <= (r_req_rptr == ReqPtrW'(ReqDepth - 1)) ? '0 : r_req_rptr + 1'b1;
            if (w_req_push && !w_req_pop)      r_req_cnt <= r_req_cnt + 1'b1;
            else if (!w_req_push && w_req_pop) r_req_cnt <= r_req_cnt - 1'b1;

            if (w_rsp_push)
                r_rsp_wptr <= (r_rsp_wptr == RspPtrW'(MaxOutstanding - 1)) ? '0 : r_rsp_wptr + 1'b1;
            if (w_rsp_pop)
                r_rsp_rptr <= (r_rsp_rptr == RspPtrW'(MaxOutstanding - 1)) ? '0 : r_rsp_rptr + 1'b1;
            if (w_rsp_push && !w_rsp_pop)      r_rsp_cnt <= r_rsp_cnt + 1'b1;
            else if (!w_rsp_push && w_rsp_pop) r_rsp_cnt <= r_rsp_cnt - 1'b1;

            // Outstanding spans accept upstream until the response leaves upstream.
            if (w_req_push && !w_rsp_pop)      r_out_cnt <= r_out_cnt + 1'b1;
            else if (!w_req_push && w_rsp_pop) r_out_cnt <= r_out_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/mempool_group_link.sv
// Registered, flow-controlled TCDM link between two groups: independent
// per-tile lanes, shared sticky protocol-error flag and idle indication.
module mempool_group_link
    import mempool_group_link_pkg::*;
#(
    parameter int unsigned NumLanes       = NumTilesPerGroup,
    parameter int unsigned ReqDepth       = 2,
    parameter int unsigned MaxOutstanding = LinkMaxOutstanding
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  tcdm_slave_req_t     slv_req_i        [NumLanes],
    input  logic [NumLanes-1:0] slv_req_valid_i,
    output logic [NumLanes-1:0] slv_req_ready_o,
    output tcdm_master_resp_t   slv_resp_o       [NumLanes],
    output logic [NumLanes-1:0] slv_resp_valid_o,
    input  logic [NumLanes-1:0] slv_resp_ready_i,
    output tcdm_slave_req_t     mst_req_o        [NumLanes],
    output logic [NumLanes-1:0] mst_req_valid_o,
    input  logic [NumLanes-1:0] mst_req_ready_i,
    input  tcdm_master_resp_t   mst_resp_i       [NumLanes],
    input  logic [NumLanes-1:0] mst_resp_valid_i,
    output logic [NumLanes-1:0] mst_resp_ready_o,
    output logic                idle_o,
    output logic                err_o
);

    logic [NumLanes-1:0] w_idle;
    logic [NumLanes-1:0] w_spur;
    logic                r_err;

    for (genvar g = 0; g < NumLanes; g++) begin : g_lane
        mempool_group_link_lane #(
            .ReqDepth       (ReqDepth),
            .MaxOutstanding (MaxOutstanding)
        ) u_lane (
            .clk_i            (clk_i),
            .rst_ni           (rst_ni),
            .slv_req_i        (slv_req_i[g]),
            .slv_req_valid_i  (slv_req_valid_i[g]),
            .slv_req_ready_o  (slv_req_ready_o[g]),
            .slv_resp_o       (slv_resp_o[g]),
            .slv_resp_valid_o (slv_resp_valid_o[g]),
            .slv_resp_ready_i (slv_resp_ready_i[g]),
            .mst_req_o        (mst_req_o[g]),
            .mst_req_valid_o  (mst_req_valid_o[g]),
            .mst_req_ready_i  (mst_req_ready_i[g]),
            .mst_resp_i       (mst_resp_i[g]),
            .mst_resp_valid_i (mst_resp_valid_i[g]),
            .mst_resp_ready_o (mst_resp_ready_o[g]),
            .idle_c_o         (w_idle[g]),
            .spur_c_o         (w_spur[g])
        );
    end

    // Sticky until reset: any lane receiving a response it never asked for.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_err <= 1'b0;
        else         r_err <= r_err | (|w_spur);
    end

    assign err_o  = r_err;
    assign idle_o = &w_idle;

endmodule
